// File: rtl/updown_counter_db_if.sv
// Button inputs and counter outputs of the debounced up/down counter.
interface updown_counter_db_if #(
  parameter int WIDTH = 8
) ();
  logic             east;
  logic             west;
  logic [WIDTH-1:0] led;
  logic             at_max;
  logic             at_min;

  modport master (output east, output west, input led, input at_max, input at_min);
  modport slave  (input east, input west, output led, output at_max, output at_min);
endinterface

// File: rtl/updown_counter_db.sv
// Two debounced push buttons (east = up, west = down) with optional auto-repeat
// driving a bounded signed counter that either saturates or wraps.
module updown_counter_db_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic step_o
);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic                db_q, db_d;
  logic                rise_q, rise_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;

  always_comb begin
    db_d       = db_q;
    db_cnt_d   = '0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    step_o     = 1'b0;

    // A differing level must persist unbroken; any agreement clears the count.
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
    rise_d = db_d & ~db_q;

    case (state_q)
      IDLE:   if (rise_q) state_d = PRESS;
      PRESS: begin
        step_o     = 1'b1;
        hold_cnt_d = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        if (HOLD_CYCLES > 0) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d   = REPEAT;
            rep_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      REPEAT: begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          step_o    = db_q;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!db_q) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end
  end

  // A button already held at reset loads as debounced-high, so it yields no rise.
  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
    if (reset) begin
      db_q       <= sync2_q;
      rise_q     <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      state_q    <= IDLE;
    end else begin
      db_q       <= db_d;
      rise_q     <= rise_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      state_q    <= state_d;
    end
  end
endmodule

module updown_counter_db #(
  parameter int WIDTH           = 8,
  parameter int MIN             = -8,
  parameter int MAX             = 7,
  parameter int STEP            = 1,
  parameter int RESET_VAL       = 0,
  parameter int WRAP            = 0,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic               clk,
  input  logic               reset,
  updown_counter_db_if.slave bus
);
  localparam logic signed [WIDTH:0]   MIN_X   = (WIDTH+1)'(MIN);
  localparam logic signed [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX);
  localparam logic signed [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH-1:0] MIN_W   = WIDTH'(MIN);
  localparam logic signed [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic signed [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic                    up_step, dn_step;
  logic signed [WIDTH-1:0] led_q, led_d;
  logic                    at_max_q, at_max_d, at_min_q, at_min_d;
  logic signed [WIDTH:0]   led_x, sum_x;

  function automatic logic signed [WIDTH:0] inc_f(input logic signed [WIDTH:0] v);
    logic signed [WIDTH:0] s;
    s = v + STEP_X;
    if (s > MAX_X) return (WRAP != 0) ? MIN_X : MAX_X;
    return s;
  endfunction

  function automatic logic signed [WIDTH:0] dec_f(input logic signed [WIDTH:0] v);
    logic signed [WIDTH:0] s;
    s = v - STEP_X;
    if (s < MIN_X) return (WRAP != 0) ? MAX_X : MIN_X;
    return s;
  endfunction

  updown_counter_db_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_east (.clk(clk), .reset(reset), .btn_i(bus.east), .step_o(up_step));

  updown_counter_db_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_west (.clk(clk), .reset(reset), .btn_i(bus.west), .step_o(dn_step));

  // Simultaneous up and down steps cancel.
  always_comb begin
    led_x = {led_q[WIDTH-1], led_q};
    sum_x = led_x;
    if (up_step && !dn_step)      sum_x = inc_f(led_x);
    else if (dn_step && !up_step) sum_x = dec_f(led_x);
    led_d    = sum_x[WIDTH-1:0];
    at_max_d = (led_d == MAX_W);
    at_min_d = (led_d == MIN_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q    <= RESET_W;
      at_max_q <= (RESET_W == MAX_W);
      at_min_q <= (RESET_W == MIN_W);
    end else begin
      led_q    <= led_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.at_max = at_max_q;
  assign bus.at_min = at_min_q;
endmodule

// File: tb/tb_updown_counter_db.sv
// Directed bench for updown_counter_db: a saturating and a wrapping instance,
// led changes checked against a scoreboard of expected (cycle, value) events.
module tb_updown_counter_db;
  localparam int D   = 4;
  localparam int H   = 10;
  localparam int R   = 3;
  localparam int LAT = D + 3;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   mdl [2];
  ev_t  qa [$];
  ev_t  qb [$];
  logic [7:0] prev_a, prev_b;

  updown_counter_db_if #(.WIDTH(8)) ifa ();
  updown_counter_db_if #(.WIDTH(8)) ifb ();

  updown_counter_db #(
    .WIDTH(8), .WRAP(0), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  updown_counter_db #(
    .WIDTH(8), .WRAP(1), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nxt(input int v, input bit up, input bit wrap);
    int s;
    s = up ? v + 1 : v - 1;
    if (s > 7)  return wrap ? -8 : 7;
    if (s < -8) return wrap ? 7 : -8;
    return s;
  endfunction

  task automatic sched(input int d, input int c, input int v);
    ev_t e;
    if (v != mdl[d]) begin
      e.cyc = c;
      e.val = v;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
      mdl[d] = v;
    end
  endtask

  task automatic mon(input int d, input logic [7:0] led);
    ev_t e;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      check(d == 0 ? "unexpected_chg_a" : "unexpected_chg_b", $signed(led), mdl[d]);
    end else begin
      e = (d == 0) ? qa.pop_front() : qb.pop_front();
      check(d == 0 ? "ev_val_a" : "ev_val_b", $signed(led), e.val);
      check(d == 0 ? "ev_cyc_a" : "ev_cyc_b", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifa.led !== prev_a) mon(0, ifa.led);
      if (ifb.led !== prev_b) mon(1, ifb.led);
    end
    prev_a <= ifa.led;
    prev_b <= ifb.led;
  end

  task automatic set_btn(input int d, input bit up, input logic v);
    if (d == 0) begin
      if (up) ifa.east = v; else ifa.west = v;
    end else begin
      if (up) ifb.east = v; else ifb.west = v;
    end
  endtask

  // One clean press: first step LAT after the press, repeats while the level stays debounced-high.
  task automatic press(input int d, input bit up, input int hi, input int lo);
    int c;
    c = cyc;
    set_btn(d, up, 1'b1);
    sched(d, c + 1 + LAT, nxt(mdl[d], up, d == 1));
    for (int k = 1; LAT + H + R * k <= hi + D + 1; k++)
      sched(d, c + 1 + LAT + H + R * k, nxt(mdl[d], up, d == 1));
    repeat (hi) @(negedge clk);
    set_btn(d, up, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    int c;
    c = cyc;
    reset = 1'b1;
    sched(0, c + 1, 0);
    sched(1, c + 1, 0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ifa.east = 1'b0; ifa.west = 1'b0;
    ifb.east = 1'b0; ifb.west = 1'b0;
    mdl[0] = 0; mdl[1] = 0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    check("rst_led", $signed(ifa.led), 0);
    check("rst_at_max", {31'b0, ifa.at_max}, 0);
    check("rst_at_min", {31'b0, ifa.at_min}, 0);

    // Clean press held without reaching auto-repeat.
    press(0, 1'b1, 12, 10);
    check("clean_press_led", $signed(ifa.led), 1);

    // Bounce 1,0,1,0 then stable.
    set_btn(0, 1'b1, 1'b1); @(negedge clk);
    set_btn(0, 1'b1, 1'b0); @(negedge clk);
    set_btn(0, 1'b1, 1'b1); @(negedge clk);
    set_btn(0, 1'b1, 1'b0); @(negedge clk);
    press(0, 1'b1, 8, 8);
    check("bounce_led", $signed(ifa.led), 2);

    // East and west together cancel.
    ifa.east = 1'b1; ifa.west = 1'b1;
    repeat (8) @(negedge clk);
    ifa.east = 1'b0; ifa.west = 1'b0;
    repeat (8) @(negedge clk);
    check("cancel_led", $signed(ifa.led), 2);

    // Saturation at MAX.
    for (int i = 0; i < 4; i++) press(0, 1'b1, 8, 8);
    check("sat_pre_led", $signed(ifa.led), 6);
    for (int i = 0; i < 3; i++) press(0, 1'b1, 8, 8);
    check("sat_led", $signed(ifa.led), 7);
    check("sat_at_max", {31'b0, ifa.at_max}, 1);
    check("sat_at_min", {31'b0, ifa.at_min}, 0);

    // Wrap past MAX.
    for (int i = 0; i < 6; i++) press(1, 1'b1, 8, 8);
    check("wrap_pre_led", $signed(ifb.led), 6);
    press(1, 1'b1, 8, 8);
    check("wrap_led_7", $signed(ifb.led), 7);
    check("wrap_at_max", {31'b0, ifb.at_max}, 1);
    press(1, 1'b1, 8, 8);
    check("wrap_led_m8", $signed(ifb.led), -8);
    check("wrap_at_min", {31'b0, ifb.at_min}, 1);
    check("wrap_at_max_lo", {31'b0, ifb.at_max}, 0);
    press(1, 1'b1, 8, 8);
    check("wrap_led_m7", $signed(ifb.led), -7);
    check("wrap_at_min_off", {31'b0, ifb.at_min}, 0);

    // Held west with auto-repeat from zero.
    do_reset(2);
    repeat (4) @(negedge clk);
    check("rst2_led", $signed(ifa.led), 0);
    press(0, 1'b0, 30, 10);
    check("repeat_led", $signed(ifa.led), -7);

    // Reset two clocks into a debounce aborts the press.
    ifa.east = 1'b1;
    repeat (3) @(negedge clk);
    do_reset(2);
    repeat (10) @(negedge clk);
    ifa.east = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_led", $signed(ifa.led), 0);
    check("abort_at_min", {31'b0, ifa.at_min}, 0);
    check("abort_at_max", {31'b0, ifa.at_max}, 0);

    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
